// File: rtl/ahb_decoder_mux_n_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } dstate_e;

endpackage

// File: rtl/ahb_decoder_mux_n_if.sv
// Master-side AHB-Lite signals seen by the decoder/mux, plus per-slave responses.
interface ahb_decoder_mux_n_if #(
    parameter int NUM_S  = 2,
    parameter int DATA_W = 32
);
    logic [31:0]                   HADDR;
    logic [1:0]                    HTRANS;
    logic [NUM_S-1:0]              HREADYOUT_S;
    logic [NUM_S-1:0]              HRESP_S;
    logic [NUM_S-1:0][DATA_W-1:0]  HRDATA_S;
    logic [NUM_S-1:0]              HSEL;
    logic                          HSEL_DEF;
    logic                          HREADY;
    logic                          HRESP;
    logic [DATA_W-1:0]             HRDATA;

    modport slave (
        input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
        output HSEL, HSEL_DEF, HREADY, HRESP, HRDATA
    );

    modport master (
        output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
        input  HSEL, HSEL_DEF, HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_decoder_mux_n_default_slave.sv
// Default slave: two-cycle ERROR for active transfers to unmapped space, OKAY otherwise.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic       HSEL_DEF,
    input  logic [1:0] HTRANS,
    output logic       HREADYOUT,
    output logic       HRESP
);

    dstate_e state_q, state_d;
    logic    dtrans_q, dtrans_d;
    logic    active;
    logic    start;

    assign active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign start  = HREADY && HSEL_DEF && active;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= D_IDLE;
            dtrans_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dtrans_q <= dtrans_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dtrans_d  = HREADY ? (HSEL_DEF && active) : dtrans_q;
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        case (state_q)
            D_IDLE: if (start) state_d = D_ERR1;
            D_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
                state_d   = D_ERR2;
            end
            D_ERR2: begin
                HRESP   = RESP_ERROR;
                state_d = start ? D_ERR1 : D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

    // The first ERROR cycle can only follow an accepted unmapped active transfer.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state_q == D_ERR1) assert (dtrans_q);
    end

endmodule

// File: rtl/ahb_decoder_mux_n.sv
// N-region AHB-Lite address decoder with data-phase response mux and built-in default slave.
module ahb_decoder_mux_n
    import ahb_pkg::*;
#(
    parameter int                    NUM_S  = 2,
    parameter int                    DATA_W = 32,
    parameter logic [NUM_S-1:0][31:0] BASE  = {32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_S-1:0][31:0] SIZE  = {32'h0000_1000, 32'h0000_8000}
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_decoder_mux_n_if.slave  bus
);

    logic [NUM_S-1:0] hit;
    logic [NUM_S-1:0] hsel;
    logic             hsel_def;
    logic [NUM_S:0]   dsel_q, dsel_d;
    logic             def_ready, def_resp;

    for (genvar i = 0; i < NUM_S; i++) begin : g_region
        localparam logic [32:0] LO = {1'b0, BASE[i]};
        localparam logic [32:0] HI = {1'b0, BASE[i]} + {1'b0, SIZE[i]} - 33'd1;

        assign hit[i] = ({1'b0, bus.HADDR} >= LO) && ({1'b0, bus.HADDR} <= HI);

        always_ff @(posedge HCLK) begin
            assert (SIZE[i] != 32'd0 && ({1'b0, BASE[i]} + {1'b0, SIZE[i]}) <= 33'h1_0000_0000);
        end
    end

    // Lowest index wins on overlap so the select stays one-hot.
    always_comb begin
        hsel = '0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (hit[i]) hsel = NUM_S'(1) << i;
        end
    end

    assign hsel_def     = ~|hsel;
    assign bus.HSEL     = hsel;
    assign bus.HSEL_DEF = hsel_def;

    assign dsel_d = bus.HREADY ? {hsel_def, hsel} : dsel_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) dsel_q <= {1'b1, {NUM_S{1'b0}}};
        else        dsel_q <= dsel_d;
    end

    ahb_default_slave u_def (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (bus.HREADY),
        .HSEL_DEF  (hsel_def),
        .HTRANS    (bus.HTRANS),
        .HREADYOUT (def_ready),
        .HRESP     (def_resp)
    );

    always_comb begin
        bus.HREADY = def_ready;
        bus.HRESP  = def_resp;
        bus.HRDATA = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (dsel_q[i]) begin
                bus.HREADY = bus.HREADYOUT_S[i];
                bus.HRESP  = bus.HRESP_S[i];
                bus.HRDATA = bus.HRDATA_S[i];
            end
        end
        if (HRESET) begin
            bus.HREADY = 1'b1;
            bus.HRESP  = RESP_OKAY;
            bus.HRDATA = '0;
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux_n.sv
// Directed bench: decode boundaries, wait states, default-slave ERROR timing, reset abort, overlap.
module tb_ahb_decoder_mux_n;

    logic HCLK = 1'b0;
    logic HRESET;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 HCLK = ~HCLK;

    ahb_decoder_mux_n_if #(.NUM_S(2), .DATA_W(32)) bus0 ();
    ahb_decoder_mux_n_if #(.NUM_S(2), .DATA_W(32)) bus1 ();

    ahb_decoder_mux_n #(.NUM_S(2), .DATA_W(32)) u0 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus0)
    );

    ahb_decoder_mux_n #(
        .NUM_S  (2),
        .DATA_W (32),
        .BASE   ({32'h1000_0000, 32'h1000_0000}),
        .SIZE   ({32'h0000_1000, 32'h0000_0100})
    ) u1 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        bus0.HADDR  = a;
        bus0.HTRANS = t;
        #1;
    endtask

    task automatic resp(input string tag, input logic rdy, input logic rsp, input logic [31:0] d);
        chk({tag, ".HREADY"}, 64'(bus0.HREADY), 64'(rdy));
        chk({tag, ".HRESP"},  64'(bus0.HRESP),  64'(rsp));
        chk({tag, ".HRDATA"}, 64'(bus0.HRDATA), 64'(d));
    endtask

    initial begin
        HRESET           = 1'b1;
        bus0.HADDR       = '0;
        bus0.HTRANS      = 2'b00;
        bus0.HREADYOUT_S = 2'b11;
        bus0.HRESP_S     = 2'b00;
        bus0.HRDATA_S[0] = 32'h1111_1111;
        bus0.HRDATA_S[1] = 32'h2222_2222;
        bus1.HADDR       = '0;
        bus1.HTRANS      = 2'b00;
        bus1.HREADYOUT_S = 2'b11;
        bus1.HRESP_S     = 2'b00;
        bus1.HRDATA_S    = '0;

        nxt(); #1;
        resp("reset", 1'b1, 1'b0, 32'h0);
        nxt();
        HRESET = 1'b0;
        drive(32'h0, 2'b00);
        resp("post_reset", 1'b1, 1'b0, 32'h0);

        // Decode boundaries with IDLE transfers (no FSM effect).
        drive(32'h0FFF_FFFF, 2'b00); chk("dec_below_r0", 64'(bus0.HSEL_DEF), 64'd1);
        drive(32'h1000_0000, 2'b00); chk("dec_r0_lo",    64'(bus0.HSEL),     64'd1);
        drive(32'h2000_0FFF, 2'b00); chk("dec_r1_hi",    64'(bus0.HSEL),     64'd2);
        drive(32'h2000_1000, 2'b00); chk("dec_above_r1", 64'(bus0.HSEL_DEF), 64'd1);
        drive(32'hFFFF_FFFF, 2'b00); chk("dec_top",      64'(bus0.HSEL),     64'd0);

        // Last word of region 0, then first unmapped word after it.
        nxt(); drive(32'h1000_7FFC, 2'b10);
        chk("t1_hsel", 64'(bus0.HSEL), 64'd1);
        nxt(); drive(32'h1000_8000, 2'b10);
        chk("t1_hsel_def", 64'(bus0.HSEL_DEF), 64'd1);
        resp("t1_s0_data", 1'b1, 1'b0, 32'h1111_1111);
        nxt(); drive(32'h0, 2'b00);
        resp("t1_err1", 1'b0, 1'b1, 32'h0);
        nxt(); #1;
        resp("t1_err2", 1'b1, 1'b1, 32'h0);
        nxt(); #1;
        resp("t1_idle", 1'b1, 1'b0, 32'h0);

        // Slave 1 inserts three wait states while the next address is pending.
        bus0.HREADYOUT_S = 2'b01;
        bus0.HRDATA_S[1] = 32'hCAFE_F00D;
        drive(32'h2000_0000, 2'b10);
        chk("t2_hsel", 64'(bus0.HSEL), 64'd2);
        for (int k = 0; k < 3; k++) begin
            nxt(); drive(32'h1000_0000, 2'b10);
            chk("t2_wait_hsel", 64'(bus0.HSEL), 64'd1);
            resp("t2_wait", 1'b0, 1'b0, 32'hCAFE_F00D);
        end
        nxt();
        bus0.HREADYOUT_S = 2'b11;
        #1;
        resp("t2_done", 1'b1, 1'b0, 32'hCAFE_F00D);
        nxt(); drive(32'h0, 2'b00);
        chk("t3_hsel_def", 64'(bus0.HSEL_DEF), 64'd1);
        resp("t2_next_s0", 1'b1, 1'b0, 32'h1111_1111);

        // IDLE to unmapped space is a zero-wait OKAY.
        nxt(); #1;
        resp("t3_idle_okay", 1'b1, 1'b0, 32'h0);

        // Back-to-back unmapped NONSEQ: ERR1, ERR2, ERR1, ERR2.
        drive(32'h3000_0000, 2'b10);
        chk("t4_hsel_def", 64'(bus0.HSEL_DEF), 64'd1);
        nxt(); drive(32'h3000_0004, 2'b10);
        resp("t4_a_err1", 1'b0, 1'b1, 32'h0);
        nxt(); #1;
        resp("t4_a_err2", 1'b1, 1'b1, 32'h0);
        nxt(); drive(32'h0, 2'b00);
        resp("t4_b_err1", 1'b0, 1'b1, 32'h0);
        nxt(); #1;
        resp("t4_b_err2", 1'b1, 1'b1, 32'h0);
        nxt(); #1;
        resp("t4_idle", 1'b1, 1'b0, 32'h0);

        // Reset while the default slave is in its first ERROR cycle.
        drive(32'h3000_0000, 2'b10);
        nxt(); drive(32'h0, 2'b00);
        resp("t6_err1", 1'b0, 1'b1, 32'h0);
        HRESET = 1'b1;
        #1;
        resp("t6_in_reset", 1'b1, 1'b0, 32'h0);
        nxt();
        HRESET = 1'b0;
        #1;
        resp("t6_after", 1'b1, 1'b0, 32'h0);
        nxt(); #1;
        resp("t6_after2", 1'b1, 1'b0, 32'h0);

        // Overlapping regions: lowest index wins.
        bus1.HADDR = 32'h1000_0010; #1;
        chk("t5_overlap", 64'(bus1.HSEL), 64'd1);
        bus1.HADDR = 32'h1000_0200; #1;
        chk("t5_r1_only", 64'(bus1.HSEL), 64'd2);
        bus1.HADDR = 32'h1000_1000; #1;
        chk("t5_outside", 64'(bus1.HSEL_DEF), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
